fifo_queue: RTL and testbench
=============================

# fifo_queue

Parameterised single-clock circular FIFO used throughout the pipeline for inter-stage queues and the rename-stage physical-register free list. It accepts one push and one pop per cycle and presents the head entry combinationally (first-word fall-through). Full/empty flags and a synchronous flush are provided. An optional reset-time preload makes it usable as a free list of physical register indices.

## Interface
- DATA_WIDTH, 32: entry width in bits.
- ADDR_WIDTH, 4: pointer width; depth D = 2^ADDR_WIDTH.
- SHOW_DEBUG, 0: nonzero enables simulation-only push/pop/flush messages.
- INIT_CODE, 0: 0 = reset to empty; 1 = reset preloaded as a free list.
- QUEUE_NAME, "QUEUE": string prefixed to debug messages.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- pushReq_IN  in  1  write data_IN at tail this edge.
- data_IN  in  DATA_WIDTH  push data.
- popReq_IN  in  1  retire head entry this edge.
- data_OUT  out  DATA_WIDTH  current head entry, combinational.
- fullFlag_OUT  out  1  count == D.
- emptyFlag_OUT  out  1  count == 0.
- flush_IN  in  1  synchronous clear to empty.

## Operation
- State: storage mem[D], head and tail pointers (ADDR_WIDTH bits, natural wrap D-1→0), count (ADDR_WIDTH+1 bits).
- Flags are decoded from count. data_OUT = mem[head] when count>0, else 0.
- Reset with INIT_CODE=0: head=tail=0, count=0.
- Reset with INIT_CODE=1: mem[i] = D/2 + i for i in 0..D/2-1 (zero-extended to DATA_WIDTH); head=0; tail=D/2; count=D/2.
  - Example: with ADDR_WIDTH=6 the free list holds registers 32..63.
  - INIT_CODE=1 requires DATA_WIDTH ≥ ADDR_WIDTH.
- Per-edge priority: flush > push/pop.
- flush_IN=1: head=tail=0, count=0. No re-preload. Concurrent push and pop are ignored.
- Pop is effective iff popReq_IN && count>0. Effect: head+1.
- Push is effective iff pushReq_IN && (count<D || pop effective). Effect: mem[tail]=data_IN, tail+1.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Empty with both requests: only the push is effective; count becomes 1. The pushed word appears on data_OUT the next cycle.
- Full with both requests: both are effective; count stays D.
- Pop when empty and push when full (without a pop) are silently dropped. No error output.
- SHOW_DEBUG≠0: $display QUEUE_NAME, operation, data and count on every effective push, pop or flush. This must not synthesise into logic.

## Timing
- Write and pointer updates occur on the rising clk edge. Flags and data_OUT update after that edge.
- Reset is asynchronous: state is forced immediately on reset falling. Release is sampled at the next rising edge.
- Pushed data is visible on data_OUT one cycle after the push edge, when the queue was empty.
- Popping consumers read data_OUT in the same cycle they assert popReq_IN.
- Reset mid-operation discards all contents and pending requests.
- Output values while reset is asserted:
  - INIT_CODE=0: empty=1, full=0, data_OUT=0.
  - INIT_CODE=1: empty=0, full=0 (full=1 only if D/2==D, impossible), data_OUT=D/2.

## Structure
- No shared package required. The preload formula is a local function of ADDR_WIDTH.
- One sub-module is natural: fifo_mem, a D×DATA_WIDTH register array with one synchronous write port and one asynchronous read port.
- Pointer/count control and the debug block stay in fifo_queue.

## Test plan
- Basic ordering: INIT_CODE=0, ADDR_WIDTH=2. Push 0xA, 0xB, 0xC, 0xD → full=1 after the 4th edge. Pops return A, B, C, D in order; empty=1 after the 4th pop.
- Overflow and underflow: push 0xE while full with no pop → dropped; the later pop sequence is unchanged. Pop while empty → count stays 0, data_OUT=0.
- Simultaneous push+pop:
  - At full: count stays 4, the head advances, and the new data lands at the old tail.
  - At empty: count becomes 1, data_OUT=pushed value.
- Wrap-around: 10 alternating push/pop pairs with values 1..10. data_OUT follows the values and the pointers wrap cleanly.
- Preload: INIT_CODE=1, ADDR_WIDTH=6, DATA_WIDTH=6. After reset, 32 pops return 32..63, then empty=1. Push 5 then pop → 5.
- Flush and async reset:
  - flush_IN with 3 entries plus a concurrent push → empty=1 next cycle.
  - Drop reset mid-clock → flags go to reset values before the next edge.

Source files
------------

// File: rtl/fifo_queue_pkg.sv
// Shared definitions for the circular FIFO: preload modes, the per-edge
// operation encoding and the free-list preload formula.
package fifo_queue_pkg;

    localparam int INIT_FREELIST = 1;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifoOp_e;

    // Free-list entry i holds physical register D/2 + i, D = 2^addrWidth.
    function automatic int unsigned preloadEntry(input int unsigned addrWidth,
                                                 input int unsigned index);
        return (32'd1 << (addrWidth - 1)) + index;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// D x DATA_WIDTH register array: one synchronous write port, one
// asynchronous read port, with an optional free-list image loaded at reset.
module fifo_mem
    import fifo_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int INIT_CODE  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  writeEnable,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [ADDR_WIDTH-1:0] readAddr,
    output logic [DATA_WIDTH-1:0] readData
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Lower half of the array carries the free-list image; the rest is zero.
    function automatic logic [DATA_WIDTH-1:0] resetValue(input int index);
        if ((INIT_CODE == INIT_FREELIST) && (index < DEPTH / 2)) begin
            return DATA_WIDTH'(preloadEntry(ADDR_WIDTH, index));
        end
        return '0;
    endfunction

    // Storage: forced to its reset image asynchronously, otherwise written at the tail.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= resetValue(i);
            end
        end else if (writeEnable) begin
            mem[writeAddr] <= writeData;
        end
    end

    assign readData = mem[readAddr];

endmodule

// File: rtl/fifo_queue.sv
// Single-clock circular FIFO with first-word fall-through head output,
// synchronous flush and optional free-list preload at reset.
module fifo_queue
    import fifo_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int SHOW_DEBUG = 0,
    parameter int INIT_CODE  = 0,
    parameter     QUEUE_NAME = "QUEUE"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pushReq_IN,
    input  logic [DATA_WIDTH-1:0] data_IN,
    input  logic                  popReq_IN,
    output logic [DATA_WIDTH-1:0] data_OUT,
    output logic                  fullFlag_OUT,
    output logic                  emptyFlag_OUT,
    input  logic                  flush_IN
);

    localparam logic [ADDR_WIDTH:0]   fullCount = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   halfCount = {2'b01, {(ADDR_WIDTH - 1){1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] halfPtr   = {1'b1, {(ADDR_WIDTH - 1){1'b0}}};
    localparam bit                    preload   = (INIT_CODE == INIT_FREELIST);

    logic [ADDR_WIDTH-1:0] headPtr;
    logic [ADDR_WIDTH-1:0] tailPtr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   nextCount;
    logic                  popEffective;
    logic                  pushEffective;
    logic [DATA_WIDTH-1:0] headData;
    fifoOp_e               opKind;

    // Decide which requests take effect; a pop frees the slot a full-queue push needs.
    always_comb begin
        popEffective  = popReq_IN && (count != '0);
        pushEffective = pushReq_IN && ((count != fullCount) || popEffective);
        opKind        = fifoOp_e'({pushEffective, popEffective});
        nextCount     = count;
        case (opKind)
            OP_PUSH: nextCount = count + 1'b1;
            OP_POP:  nextCount = count - 1'b1;
            OP_BOTH: nextCount = count;
            default: nextCount = count;
        endcase
    end

    // Pointer and occupancy state; flush overrides any concurrent push or pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headPtr <= '0;
            tailPtr <= preload ? halfPtr : '0;
            count   <= preload ? halfCount : '0;
        end else if (flush_IN) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (popEffective) begin
                headPtr <= headPtr + 1'b1;
            end
            if (pushEffective) begin
                tailPtr <= tailPtr + 1'b1;
            end
            count <= nextCount;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_CODE  (INIT_CODE)
    ) storage (
        .clk         (clk),
        .reset       (reset),
        .writeEnable (pushEffective && !flush_IN),
        .writeAddr   (tailPtr),
        .writeData   (data_IN),
        .readAddr    (headPtr),
        .readData    (headData)
    );

    assign emptyFlag_OUT = (count == '0);
    assign fullFlag_OUT  = (count == fullCount);
    assign data_OUT      = emptyFlag_OUT ? '0 : headData;

    // Simulation trace of every effective operation; count shown is the pre-edge value.
    always @(posedge clk) begin
        if ((SHOW_DEBUG != 0) && reset) begin
            if (flush_IN) begin
                $info("%s: flush count=%0d", QUEUE_NAME, count);
            end else begin
                if (pushEffective) begin
                    $info("%s: push data=%h count=%0d", QUEUE_NAME, data_IN, count);
                end
                if (popEffective) begin
                    $info("%s: pop data=%h count=%0d", QUEUE_NAME, data_OUT, count);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_queue.sv
// Self-checking bench: a depth-4 empty-reset queue and a depth-64
// free-list queue, each compared against a queue-based reference model.
module tb_fifo_queue;

    logic       clk;
    logic       rstN;

    logic       pushA, popA, flushA;
    logic [7:0] dataInA, dataOutA;
    logic       fullA, emptyA;

    logic       pushB, popB, flushB;
    logic [5:0] dataInB, dataOutB;
    logic       fullB, emptyB;

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0] modelA[$];
    logic [5:0] modelB[$];

    fifo_queue #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (2),
        .SHOW_DEBUG (0),
        .INIT_CODE  (0),
        .QUEUE_NAME ("QA")
    ) dutA (
        .clk           (clk),
        .reset         (rstN),
        .pushReq_IN    (pushA),
        .data_IN       (dataInA),
        .popReq_IN     (popA),
        .data_OUT      (dataOutA),
        .fullFlag_OUT  (fullA),
        .emptyFlag_OUT (emptyA),
        .flush_IN      (flushA)
    );

    fifo_queue #(
        .DATA_WIDTH (6),
        .ADDR_WIDTH (6),
        .SHOW_DEBUG (0),
        .INIT_CODE  (1),
        .QUEUE_NAME ("QB")
    ) dutB (
        .clk           (clk),
        .reset         (rstN),
        .pushReq_IN    (pushB),
        .data_IN       (dataInB),
        .popReq_IN     (popB),
        .data_OUT      (dataOutB),
        .fullFlag_OUT  (fullB),
        .emptyFlag_OUT (emptyB),
        .flush_IN      (flushB)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic preloadModelB();
        modelB.delete();
        for (int i = 0; i < 32; i++) begin
            modelB.push_back(6'(32 + i));
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input bit sel, input string tag);
        if (!sel) begin
            checkValue({tag, "_dataA"}, 32'(dataOutA),
                       (modelA.size() > 0) ? 32'(modelA[0]) : 32'd0);
            checkValue({tag, "_fullA"}, 32'(fullA), 32'(modelA.size() == 4));
            checkValue({tag, "_emptyA"}, 32'(emptyA), 32'(modelA.size() == 0));
        end else begin
            checkValue({tag, "_dataB"}, 32'(dataOutB),
                       (modelB.size() > 0) ? 32'(modelB[0]) : 32'd0);
            checkValue({tag, "_fullB"}, 32'(fullB), 32'(modelB.size() == 64));
            checkValue({tag, "_emptyB"}, 32'(emptyB), 32'(modelB.size() == 0));
        end
    endtask

    task automatic applyStimulus(input bit sel, input bit push, input logic [7:0] data,
                                 input bit pop, input bit flush);
        bit popOk;
        bit pushOk;
        if (!sel) begin
            pushA = push; dataInA = data; popA = pop; flushA = flush;
        end else begin
            pushB = push; dataInB = data[5:0]; popB = pop; flushB = flush;
        end
        @(posedge clk);
        #1;
        if (!sel) begin
            if (flush) begin
                modelA.delete();
            end else begin
                popOk  = pop && (modelA.size() > 0);
                pushOk = push && ((modelA.size() < 4) || popOk);
                if (popOk) void'(modelA.pop_front());
                if (pushOk) modelA.push_back(data);
            end
        end else begin
            if (flush) begin
                modelB.delete();
            end else begin
                popOk  = pop && (modelB.size() > 0);
                pushOk = push && ((modelB.size() < 64) || popOk);
                if (popOk) void'(modelB.pop_front());
                if (pushOk) modelB.push_back(data[5:0]);
            end
        end
        pushA = 1'b0; popA = 1'b0; flushA = 1'b0; dataInA = '0;
        pushB = 1'b0; popB = 1'b0; flushB = 1'b0; dataInB = '0;
    endtask

    initial begin
        rstN  = 1'b0;
        pushA = 1'b0; popA = 1'b0; flushA = 1'b0; dataInA = '0;
        pushB = 1'b0; popB = 1'b0; flushB = 1'b0; dataInB = '0;
        modelA.delete();
        preloadModelB();

        // Reset values while reset is held
        #12;
        checkOutput(0, "rstA");
        checkOutput(1, "rstB");
        checkValue("rstB_head32", 32'(dataOutB), 32'd32);
        rstN = 1'b1;

        // Basic ordering and full flag
        applyStimulus(0, 1'b1, 8'h0A, 1'b0, 1'b0); checkOutput(0, "push1");
        checkValue("firstWordFallThrough", 32'(dataOutA), 32'h0A);
        applyStimulus(0, 1'b1, 8'h0B, 1'b0, 1'b0); checkOutput(0, "push2");
        applyStimulus(0, 1'b1, 8'h0C, 1'b0, 1'b0); checkOutput(0, "push3");
        applyStimulus(0, 1'b1, 8'h0D, 1'b0, 1'b0); checkOutput(0, "push4");
        checkValue("fullAfter4", 32'(fullA), 32'd1);

        // Overflow is dropped
        applyStimulus(0, 1'b1, 8'h0E, 1'b0, 1'b0); checkOutput(0, "overflow");

        // Push+pop at full: head advances, count stays at depth
        applyStimulus(0, 1'b1, 8'h11, 1'b1, 1'b0); checkOutput(0, "bothFull");
        checkValue("bothFullHead", 32'(dataOutA), 32'h0B);
        checkValue("bothFullFlag", 32'(fullA), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0); checkOutput(0, "drain");
        end
        checkValue("emptyAfterDrain", 32'(emptyA), 32'd1);

        // Underflow is dropped
        applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0); checkOutput(0, "underflow");
        checkValue("underflowData", 32'(dataOutA), 32'd0);

        // Push+pop at empty: only the push takes effect
        applyStimulus(0, 1'b1, 8'h22, 1'b1, 1'b0); checkOutput(0, "bothEmpty");
        checkValue("bothEmptyData", 32'(dataOutA), 32'h22);
        checkValue("bothEmptyFlag", 32'(emptyA), 32'd0);
        applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0); checkOutput(0, "bothEmptyPop");

        // Wrap-around with alternating pairs
        for (int v = 1; v <= 10; v++) begin
            applyStimulus(0, 1'b1, 8'(v), 1'b0, 1'b0);
            checkValue("wrapData", 32'(dataOutA), 32'(v));
            applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0); checkOutput(0, "wrapPop");
        end

        // Randomised traffic on the small queue
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, ($urandom_range(0, 99) < 60), 8'($urandom),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
            checkOutput(0, "randA");
        end

        // Flush with three entries and a concurrent push
        applyStimulus(0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        end
        checkOutput(0, "preFlush");
        applyStimulus(0, 1'b1, 8'h77, 1'b0, 1'b1); checkOutput(0, "flush");
        checkValue("flushEmpty", 32'(emptyA), 32'd1);

        // Free list: 32 pops return 32..63
        for (int i = 0; i < 32; i++) begin
            checkValue("freeHead", 32'(dataOutB), 32'(32 + i));
            applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput(1, "freePop");
        end
        checkValue("freeEmpty", 32'(emptyB), 32'd1);
        applyStimulus(1, 1'b1, 8'h05, 1'b0, 1'b0);
        checkValue("freePush5", 32'(dataOutB), 32'd5);
        applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0); checkOutput(1, "freePop5");

        // Randomised traffic on the large queue
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1, 1'($urandom_range(0, 1)), 8'($urandom),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
            checkOutput(1, "randB");
        end

        // Asynchronous reset in the middle of a clock period
        applyStimulus(0, 1'b1, 8'h31, 1'b0, 1'b0);
        applyStimulus(0, 1'b1, 8'h32, 1'b0, 1'b0);
        checkOutput(0, "preReset");
        #3;
        rstN = 1'b0;
        #1;
        modelA.delete();
        preloadModelB();
        checkValue("asyncEmptyA", 32'(emptyA), 32'd1);
        checkValue("asyncFullA", 32'(fullA), 32'd0);
        checkValue("asyncDataA", 32'(dataOutA), 32'd0);
        checkValue("asyncDataB", 32'(dataOutB), 32'd32);
        checkValue("asyncEmptyB", 32'(emptyB), 32'd0);
        #2;
        rstN = 1'b1;
        applyStimulus(0, 1'b1, 8'h5A, 1'b0, 1'b0); checkOutput(0, "postReset");
        applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0); checkOutput(1, "postResetB");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
